// File: rtl/btb_pkg.sv
// Shared BTB types, geometry constants and PC field extraction helpers.
// Pure declarations: no latency and no flow control of their own.
package btb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int SETS      = 16;
  localparam int WAYS      = 2;
  localparam int PC_W      = 64;
  localparam int TAG_W     = 10;
  localparam int IDX_W     = $clog2(SETS);
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic             valid;
    logic             thread;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } entry_t;

  function automatic logic [IDX_W-1:0] pc_index(input logic [PC_W-1:0] pc);
    return IDX_W'(pc >> 2);
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

  function automatic logic [WAY_W-1:0] next_victim(input logic [WAY_W-1:0] ptr);
    return (ptr == WAY_W'(WAYS - 1)) ? '0 : ptr + WAY_W'(1);
  endfunction

endpackage

// File: rtl/btb_sa_if.sv
// Fetch-lookup, commit-update and flush bundle of the set-associative BTB.
// Lookup results and drop flags come back one cycle later; there is no backpressure.
interface btb_sa_if;

  logic                                         two_threads_enable;
  logic [btb_pkg::NUM_PORTS*btb_pkg::PC_W-1:0]  if_inst_pc;
  logic [btb_pkg::NUM_PORTS-1:0]                if_inst_thread;
  logic [btb_pkg::NUM_PORTS-1:0]                inst_valid;
  logic [btb_pkg::NUM_PORTS*btb_pkg::PC_W-1:0]  pc_idx;
  logic [btb_pkg::NUM_PORTS-1:0]                upd_thread;
  logic [btb_pkg::NUM_PORTS*btb_pkg::PC_W-1:0]  target_pc;
  logic [btb_pkg::NUM_PORTS-1:0]                target_pc_valid;
  logic [1:0]                                   flush_thread;
  logic [btb_pkg::NUM_PORTS*btb_pkg::PC_W-1:0]  target_inst_pc;
  logic [btb_pkg::NUM_PORTS-1:0]                target_inst_valid;
  logic [btb_pkg::NUM_PORTS-1:0]                upd_dropped;

  modport master (
    output two_threads_enable, if_inst_pc, if_inst_thread, inst_valid,
           pc_idx, upd_thread, target_pc, target_pc_valid, flush_thread,
    input  target_inst_pc, target_inst_valid, upd_dropped
  );

  modport slave (
    input  two_threads_enable, if_inst_pc, if_inst_thread, inst_valid,
           pc_idx, upd_thread, target_pc, target_pc_valid, flush_thread,
    output target_inst_pc, target_inst_valid, upd_dropped
  );

endinterface

// File: rtl/btb_set_match.sv
// Combinational tag compare across the ways of one set; the lowest matching way wins.
// Zero latency, no flow control; also hands out the set's round-robin victim way.
module btb_set_match
  import btb_pkg::*;
(
  input  entry_t [WAYS-1:0] set_entries,
  input  logic [TAG_W-1:0]  tag,
  input  logic              thread,
  input  logic              two_threads_enable,
  input  logic [WAY_W-1:0]  victim_ptr,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WAY_W-1:0]  victim_way
);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_entries[w].valid && set_entries[w].tag == tag &&
          (set_entries[w].thread == thread || !two_threads_enable)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = victim_ptr;

endmodule

// File: rtl/btb_sa.sv
// Set-associative, thread-tagged BTB with N lookup and N update ports, round-robin victims.
// Lookup latency 1 cycle; no backpressure, updates lost to set conflicts raise upd_dropped.
module btb_sa
  import btb_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  btb_sa_if.slave bus
);

  entry_t [SETS-1:0][WAYS-1:0] table_q, table_d;
  logic   [SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;

  logic [NUM_PORTS-1:0][IDX_W-1:0] lk_idx, up_idx;
  logic [NUM_PORTS-1:0][TAG_W-1:0] lk_tag, up_tag;
  logic [NUM_PORTS-1:0][PC_W-1:0]  up_tgt, fwd_tgt;
  logic [NUM_PORTS-1:0]            lk_hit, up_hit, fwd_hit;
  logic [NUM_PORTS-1:0][WAY_W-1:0] lk_way, up_hit_way, up_vic_way, lk_victim_unused;
  logic [NUM_PORTS-1:0][WAY_W-1:0] up_way;
  logic [NUM_PORTS-1:0]            up_act, up_eff, up_drop, up_wr;
  logic [NUM_PORTS-1:0]            lk_vld_d, lk_vld_q, drop_q;
  logic [NUM_PORTS-1:0][PC_W-1:0]  lk_pc_d, lk_pc_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign lk_idx[p] = pc_index(bus.if_inst_pc[p*PC_W +: PC_W]);
    assign lk_tag[p] = pc_tag(bus.if_inst_pc[p*PC_W +: PC_W]);
    assign up_idx[p] = pc_index(bus.pc_idx[p*PC_W +: PC_W]);
    assign up_tag[p] = pc_tag(bus.pc_idx[p*PC_W +: PC_W]);
    assign up_tgt[p] = bus.target_pc[p*PC_W +: PC_W];
    // Updates of a thread being flushed this cycle are discarded silently
    assign up_act[p] = bus.target_pc_valid[p] && !bus.flush_thread[bus.upd_thread[p]];

    btb_set_match u_lk_match (
      .set_entries        (table_q[lk_idx[p]]),
      .tag                (lk_tag[p]),
      .thread             (bus.if_inst_thread[p]),
      .two_threads_enable (bus.two_threads_enable),
      .victim_ptr         (ptr_q[lk_idx[p]]),
      .hit                (lk_hit[p]),
      .hit_way            (lk_way[p]),
      .victim_way         (lk_victim_unused[p])
    );

    btb_set_match u_up_match (
      .set_entries        (table_q[up_idx[p]]),
      .tag                (up_tag[p]),
      .thread             (bus.upd_thread[p]),
      .two_threads_enable (bus.two_threads_enable),
      .victim_ptr         (ptr_q[up_idx[p]]),
      .hit                (up_hit[p]),
      .hit_way            (up_hit_way[p]),
      .victim_way         (up_vic_way[p])
    );
  end

  // A higher port carrying the same branch supersedes (merges) a lower one
  always_comb begin
    up_eff = up_act;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int k = j + 1; k < NUM_PORTS; k++) begin
        if (up_act[k] && up_idx[k] == up_idx[j] && up_tag[k] == up_tag[j] &&
            (bus.upd_thread[k] == bus.upd_thread[j] || !bus.two_threads_enable))
          up_eff[j] = 1'b0;
      end
    end
  end

  // One allocation per set per cycle, and never onto a way another port is hit-writing
  always_comb begin
    up_drop = '0;
    up_way  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      up_way[j] = up_hit[j] ? up_hit_way[j] : up_vic_way[j];
      if (up_eff[j] && !up_hit[j]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (k != j && up_eff[k] && up_idx[k] == up_idx[j] &&
              ((k < j && !up_hit[k]) || (up_hit[k] && up_hit_way[k] == up_vic_way[j])))
            up_drop[j] = 1'b1;
        end
      end
    end
  end

  assign up_wr = up_eff & ~up_drop;

  always_comb begin
    table_d = table_q;
    ptr_d   = ptr_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (up_wr[j]) begin
        if (up_hit[j]) begin
          table_d[up_idx[j]][up_way[j]].target = up_tgt[j];
        end else begin
          table_d[up_idx[j]][up_way[j]] = '{valid: 1'b1, thread: bus.upd_thread[j],
                                            tag: up_tag[j], target: up_tgt[j]};
          ptr_d[up_idx[j]] = next_victim(ptr_q[up_idx[j]]);
        end
      end
    end
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.flush_thread[table_d[s][w].thread])
          table_d[s][w].valid = 1'b0;
      end
    end
  end

  // Highest-numbered committed update wins when several forward to one lookup
  always_comb begin
    fwd_hit = '0;
    fwd_tgt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (up_wr[j] && up_idx[j] == lk_idx[i] && up_tag[j] == lk_tag[i] &&
            (bus.upd_thread[j] == bus.if_inst_thread[i] || !bus.two_threads_enable)) begin
          fwd_hit[i] = 1'b1;
          fwd_tgt[i] = up_tgt[j];
        end
      end
    end
  end

  always_comb begin
    lk_vld_d = '0;
    lk_pc_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.inst_valid[i] && !bus.flush_thread[bus.if_inst_thread[i]]) begin
        if (fwd_hit[i]) begin
          lk_vld_d[i] = 1'b1;
          lk_pc_d[i]  = fwd_tgt[i];
        end else if (lk_hit[i]) begin
          lk_vld_d[i] = 1'b1;
          lk_pc_d[i]  = table_q[lk_idx[i]][lk_way[i]].target;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      table_q  <= '0;
      ptr_q    <= '0;
      lk_vld_q <= '0;
      lk_pc_q  <= '0;
      drop_q   <= '0;
    end else begin
      table_q  <= table_d;
      ptr_q    <= ptr_d;
      lk_vld_q <= lk_vld_d;
      lk_pc_q  <= lk_pc_d;
      drop_q   <= up_drop;
    end
  end

  assign bus.target_inst_valid = lk_vld_q;
  assign bus.target_inst_pc    = lk_pc_q;
  assign bus.upd_dropped       = drop_q;

endmodule

// File: tb/tb_btb_sa.sv
// Randomised scoreboard bench for btb_sa against a behavioural BTB model.
// Stimulus at negedge pushes expectations; an independent monitor pops them after each posedge.
module tb_btb_sa;
  import btb_pkg::*;

  localparam int NP = NUM_PORTS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  btb_sa_if bus();

  btb_sa u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        d_2t;
  logic [63:0] d_lpc [NP];
  logic        d_lthr[NP];
  logic        d_lvld[NP];
  logic [63:0] d_upc [NP];
  logic [63:0] d_utgt[NP];
  logic        d_uthr[NP];
  logic        d_uvld[NP];
  logic [1:0]  d_flush;

  // Reference table: what each way of each set holds, plus its round-robin pointer
  bit          mv  [SETS][WAYS];
  bit          mt  [SETS][WAYS];
  int          mtag[SETS][WAYS];
  logic [63:0] mtgt[SETS][WAYS];
  int          mptr[SETS];

  typedef struct packed {
    logic [NP-1:0]        v;
    logic [NP-1:0][63:0]  pc;
    logic [NP-1:0]        drop;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int set_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(SETS));
  endfunction

  function automatic int tag_of(input logic [63:0] pc);
    return int'((pc >> (IDX_W + 2)) % (64'd1 << TAG_W));
  endfunction

  function automatic bit same_key(input logic [63:0] a, input bit ta,
                                  input logic [63:0] b, input bit tb);
    return set_of(a) == set_of(b) && tag_of(a) == tag_of(b) && (ta == tb || !d_2t);
  endfunction

  function automatic bit entry_hit(input int s, input int w, input int tg, input bit th);
    return mv[s][w] && mtag[s][w] == tg && (mt[s][w] == th || !d_2t);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0; mt[s][w] = 0; mtag[s][w] = 0; mtgt[s][w] = '0;
      end
    end
  endtask

  task automatic model_push();
    exp_t e;
    bit act[NP], live[NP], hit[NP], lost[NP], wr[NP];
    int s[NP], tg[NP], way[NP];
    bit got;
    logic [63:0] t;
    e = '0;
    for (int j = 0; j < NP; j++) begin
      s[j] = set_of(d_upc[j]); tg[j] = tag_of(d_upc[j]);
      act[j] = d_uvld[j] && !d_flush[d_uthr[j]];
      hit[j] = 0; way[j] = 0; lost[j] = 0;
    end
    for (int j = 0; j < NP; j++) begin
      live[j] = act[j];
      for (int k = j + 1; k < NP; k++)
        if (act[k] && same_key(d_upc[j], d_uthr[j], d_upc[k], d_uthr[k])) live[j] = 0;
    end
    for (int j = 0; j < NP; j++)
      if (live[j])
        for (int w = WAYS - 1; w >= 0; w--)
          if (entry_hit(s[j], w, tg[j], d_uthr[j])) begin hit[j] = 1; way[j] = w; end
    for (int j = 0; j < NP; j++) begin
      if (live[j] && !hit[j]) begin
        way[j] = mptr[s[j]];
        for (int k = 0; k < NP; k++)
          if (k != j && live[k] && s[k] == s[j] &&
              ((k < j && !hit[k]) || (hit[k] && way[k] == mptr[s[j]]))) lost[j] = 1;
      end
    end
    for (int j = 0; j < NP; j++) begin
      wr[j] = live[j] && !lost[j];
      e.drop[j] = live[j] && !hit[j] && lost[j];
    end
    for (int i = 0; i < NP; i++) begin
      got = 0; t = '0;
      if (d_lvld[i] && !d_flush[d_lthr[i]]) begin
        for (int w = WAYS - 1; w >= 0; w--)
          if (entry_hit(set_of(d_lpc[i]), w, tag_of(d_lpc[i]), d_lthr[i])) begin
            got = 1; t = mtgt[set_of(d_lpc[i])][w];
          end
        for (int j = 0; j < NP; j++)
          if (wr[j] && same_key(d_lpc[i], d_lthr[i], d_upc[j], d_uthr[j])) begin
            got = 1; t = d_utgt[j];
          end
      end
      e.v[i] = got;
      e.pc[i] = t;
    end
    for (int j = 0; j < NP; j++) begin
      if (wr[j]) begin
        mtgt[s[j]][way[j]] = d_utgt[j];
        if (!hit[j]) begin
          mv[s[j]][way[j]] = 1; mt[s[j]][way[j]] = d_uthr[j]; mtag[s[j]][way[j]] = tg[j];
          mptr[s[j]] = (mptr[s[j]] + 1) % WAYS;
        end
      end
    end
    for (int s2 = 0; s2 < SETS; s2++)
      for (int w = 0; w < WAYS; w++)
        if (d_flush[mt[s2][w]]) mv[s2][w] = 0;
    sb.push_back(e);
  endtask

  task automatic drive();
    bus.two_threads_enable = d_2t;
    bus.flush_thread       = d_flush;
    for (int p = 0; p < NP; p++) begin
      bus.if_inst_pc[p*PC_W +: PC_W] = d_lpc[p];
      bus.if_inst_thread[p]          = d_lthr[p];
      bus.inst_valid[p]              = d_lvld[p];
      bus.pc_idx[p*PC_W +: PC_W]     = d_upc[p];
      bus.target_pc[p*PC_W +: PC_W]  = d_utgt[p];
      bus.upd_thread[p]              = d_uthr[p];
      bus.target_pc_valid[p]         = d_uvld[p];
    end
  endtask

  task automatic idle();
    d_flush = 2'b00;
    for (int p = 0; p < NP; p++) begin
      d_lpc[p] = '0; d_lthr[p] = 0; d_lvld[p] = 0;
      d_upc[p] = '0; d_utgt[p] = '0; d_uthr[p] = 0; d_uvld[p] = 0;
    end
  endtask

  task automatic set_lk(input int p, input logic [63:0] pc, input logic thr);
    d_lvld[p] = 1; d_lpc[p] = pc; d_lthr[p] = thr;
  endtask

  task automatic set_up(input int p, input logic [63:0] pc, input logic [63:0] tgt, input logic thr);
    d_uvld[p] = 1; d_upc[p] = pc; d_utgt[p] = tgt; d_uthr[p] = thr;
  endtask

  task automatic step();
    @(negedge clock);
    drive();
    model_push();
    @(posedge clock);
    #2;
  endtask

  task automatic expect_lk(input int p, input logic v, input logic [63:0] pc, input string name);
    check({name, "_valid"}, 64'(bus.target_inst_valid[p]), 64'(v));
    check({name, "_pc"}, bus.target_inst_pc[p*PC_W +: PC_W], pc);
  endtask

  task automatic expect_zero_outputs(input string name);
    check({name, "_valid"}, 64'(bus.target_inst_valid), 64'd0);
    check({name, "_pc"}, bus.target_inst_pc[63:0] | bus.target_inst_pc[127:64], 64'd0);
    check({name, "_drop"}, 64'(bus.upd_dropped), 64'd0);
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] pc;
    pc = {16'h0, 32'($urandom), 16'h0};
    pc = pc | (64'($urandom_range(0, 3)) << (IDX_W + 2)) |
              (64'($urandom_range(0, 3)) << 2) | 64'($urandom_range(0, 3));
    return pc;
  endfunction

  // Monitor: compares every DUT output cycle for which an expectation is queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        for (int p = 0; p < NP; p++) begin
          check($sformatf("sb_valid_p%0d", p), 64'(bus.target_inst_valid[p]), 64'(e.v[p]));
          check($sformatf("sb_pc_p%0d", p), bus.target_inst_pc[p*PC_W +: PC_W], e.pc[p]);
          check($sformatf("sb_drop_p%0d", p), 64'(bus.upd_dropped[p]), 64'(e.drop[p]));
        end
      end
    end
  end

  initial begin
    d_2t = 0;
    idle();
    drive();
    model_reset();
    #12;
    expect_zero_outputs("reset");
    @(posedge clock); #2;
    reset = 1'b1;

    idle(); set_lk(0, 64'h90, 0); step();
    expect_lk(0, 0, 64'h0, "first_lookup");

    idle(); set_up(0, 64'h90, 64'h10, 0); set_up(1, 64'h94, 64'h2c, 0); step();
    idle(); set_lk(0, 64'h90, 0); set_lk(1, 64'h94, 0); step();
    expect_lk(0, 1, 64'h10, "hit_90");
    expect_lk(1, 1, 64'h2c, "hit_94");

    idle(); set_up(0, 64'h30, 64'h80, 0); set_lk(1, 64'h30, 0); step();
    expect_lk(1, 1, 64'h80, "fwd_30");
    idle(); set_lk(1, 64'h30, 0); step();
    expect_lk(1, 1, 64'h80, "table_30");

    idle(); set_up(0, 64'h00, 64'h1000, 0); step();
    idle(); set_up(0, 64'h40, 64'h1040, 0); step();
    idle(); set_up(0, 64'h80, 64'h1080, 0); step();
    idle(); set_lk(0, 64'h00, 0); set_lk(1, 64'h40, 0); step();
    expect_lk(0, 0, 64'h0, "evicted_00");
    expect_lk(1, 1, 64'h1040, "kept_40");
    idle(); set_lk(0, 64'h80, 0); step();
    expect_lk(0, 1, 64'h1080, "kept_80");

    idle(); set_up(0, 64'h100, 64'h2100, 0); set_up(1, 64'h140, 64'h2140, 0); step();
    check("conflict_drop", 64'(bus.upd_dropped), 64'b10);
    idle(); set_lk(0, 64'h100, 0); set_lk(1, 64'h140, 0); step();
    expect_lk(0, 1, 64'h2100, "alloc_100");
    expect_lk(1, 0, 64'h0, "dropped_140");

    // Asynchronous reset in the middle of a cycle, outputs currently non-zero
    #1;
    reset = 1'b0;
    #1;
    expect_zero_outputs("midreset");
    model_reset();
    @(posedge clock); #2;
    reset = 1'b1;

    d_2t = 1;
    idle(); set_up(0, 64'h94, 64'h3094, 0); set_up(1, 64'h90, 64'h44, 1); step();
    idle(); set_lk(0, 64'h90, 0); set_lk(1, 64'h90, 1); step();
    expect_lk(0, 0, 64'h0, "t0_90_miss");
    expect_lk(1, 1, 64'h44, "t1_90_hit");
    idle(); d_flush = 2'b10; set_lk(1, 64'h90, 1); step();
    expect_lk(1, 0, 64'h0, "flush_same_cycle");
    idle(); set_lk(0, 64'h94, 0); set_lk(1, 64'h90, 1); step();
    expect_lk(0, 1, 64'h3094, "t0_94_survives");
    expect_lk(1, 0, 64'h0, "t1_90_flushed");
    idle(); set_lk(0, 64'h90, 0); step();
    expect_lk(0, 0, 64'h0, "t0_90_still_miss");

    idle(); d_flush = 2'b10; set_up(1, 64'h98, 64'h98, 1); set_lk(0, 64'h98, 1); step();
    check("flush_upd_drop", 64'(bus.upd_dropped), 64'd0);
    expect_lk(0, 0, 64'h0, "flush_no_fwd");
    idle(); set_lk(0, 64'h98, 1); step();
    expect_lk(0, 0, 64'h0, "flush_upd_discard");

    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 99) == 0) d_2t = ~d_2t;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 9) < 6) set_lk(p, rand_pc(), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 9) < 5)
          set_up(p, rand_pc(), {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
      end
      d_flush[0] = ($urandom_range(0, 24) == 0);
      d_flush[1] = ($urandom_range(0, 24) == 0);
      step();
    end

    idle();
    @(posedge clock); #3;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_sa.md
Name: btb_sa

Overview:
- Parametrised, set-associative branch target buffer for the superscalar fetch stage. Successor to the direct-mapped 2-port BTB.
- Adds N lookup and N update ports, WAYS-way sets with tag compare, and per-set round-robin replacement.
- Adds thread-tagged entries for two-thread mode, per-thread flush, and same-cycle update-to-lookup forwarding.
- Fetch presents PCs and receives the predicted target one cycle later. Commit/execute writes resolved taken-branch targets.

Parameters:
- NUM_PORTS, 2, number of lookup ports and number of update ports.
- SETS, 16, number of sets; power of 2; IDX_W = log2(SETS).
- WAYS, 2, ways per set; power of 2.
- PC_W, 64, PC and target width.
- TAG_W, 10, tag bits taken from PC[IDX_W+2+TAG_W-1 : IDX_W+2].

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (entries cleared while 0).
- two_threads_enable  in  1  1 = thread id takes part in tag match.
- if_inst_pc  in  NUM_PORTS*PC_W  lookup PCs; port i occupies bits [i*PC_W +: PC_W].
- if_inst_thread  in  NUM_PORTS  thread id per lookup.
- inst_valid  in  NUM_PORTS  lookup request valid.
- pc_idx  in  NUM_PORTS*PC_W  update PCs (branch PC).
- upd_thread  in  NUM_PORTS  thread id per update.
- target_pc  in  NUM_PORTS*PC_W  resolved target.
- target_pc_valid  in  NUM_PORTS  update valid.
- flush_thread  in  2  bit t invalidates all entries owned by thread t.
- target_inst_pc  out  NUM_PORTS*PC_W  predicted target, registered.
- target_inst_valid  out  NUM_PORTS  hit flag, registered.
- upd_dropped  out  NUM_PORTS  registered; 1 = update of that port discarded by a set conflict.

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2]. Low 2 PC bits are ignored.
- Entry fields: valid, thread, tag, target.
- Match: valid, tag equal, and (thread equal OR two_threads_enable==0).
- Reset (reset==0, asynchronous):
  - all valid bits, victim pointers, target_inst_pc, target_inst_valid and upd_dropped go to 0.
  - Lookups in the first cycle after reset deassertion return valid=0.
- Lookup latency is 1 cycle. Inputs sampled at posedge k appear on the outputs after posedge k.
  - Hit: target_inst_valid=1 and target_inst_pc=stored target.
  - Miss or inst_valid=0: target_inst_valid=0 and target_inst_pc=0.
- Update, applied at the posedge of the cycle it is presented:
  - On a hit in the set, overwrite the target; the victim pointer is unchanged.
  - On a miss, allocate the way at the set's victim pointer, write all fields, valid=1, and advance the pointer modulo WAYS.
- Forwarding: if an update and a lookup in the same cycle have matching index, tag and thread-rule, the lookup returns the update's target with valid=1.
  - When several updates match one lookup, the highest-numbered update port wins.
- Simultaneous updates:
  - Same PC and thread on several ports: the highest-numbered port's target is written. Lower ports are treated as merged, not dropped; upd_dropped=0.
  - Different tags, same set, two or more missing: only the lowest-numbered missing port allocates. The other missing ports are discarded and raise upd_dropped for 1 cycle.
  - Hits to distinct ways of the same set all write.
- Flush:
  - flush_thread[t] clears valid on every entry with thread==t at the posedge.
  - Flush beats any update of thread t in the same cycle; that update is discarded with upd_dropped=0.
  - Same-cycle lookups of thread t return valid=0 and forwarding from thread t is suppressed.
  - Victim pointers are not reset by flush.
- If two_threads_enable==0, flush_thread still acts on the stored thread bit.
- Reset asserted mid-operation clears state immediately. Outputs read 0 until the first lookup after release.

Decomposition:
- Package btb_pkg holds:
  - entry struct {valid, thread, tag, target};
  - index/tag extraction functions;
  - derived constants IDX_W, WAY_W.
- One sub-module, btb_set_match: combinational tag compare for one set, returning hit, hit way and the victim way. It is instantiated once per lookup port and once per update port.

Test Plan:
- Reset then lookup PC 0x90 on port 0 -> target_inst_valid=0 and target_inst_pc=0 next cycle.
- Update 0x90->0x10 and 0x94->0x2c, then lookup both next cycle -> valid=1 and targets 0x10 and 0x2c one cycle after the lookup.
- Same cycle: update 0x30->0x80 plus lookup 0x30 on port 1 -> forwarded valid=1, 0x80. Lookup of 0x30 in the following cycle -> 0x80 from the table.
- Fill set 0 (SETS=16, stride 0x40) with 0x00, 0x40, 0x80 -> 0x00 evicted (miss); 0x40 and 0x80 hit.
- Same-cycle miss-updates 0x100 (port 0) and 0x140 (port 1), both set 0 -> upd_dropped=2'b10; only 0x100 hits.
- two_threads_enable=1, thread 1 writes 0x90->0x44, then flush_thread=2'b10 -> thread-1 lookup misses.
- Thread 0 entry 0x94 survives that flush; a thread-0 lookup of 0x90 misses throughout.
